// File: rtl/front_panel_encoder_hub_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | front_panel_encoder_hub_if                                            |
// | CPU-side event FIFO / overflow bundle of the encoder hub.             |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
interface front_panel_encoder_hub_if;
    logic       evt_rd_stb;
    logic       ovf_clr;
    logic       evt_valid;
    logic [7:0] evt_data;
    logic       evt_overflow;

    modport master (
        output evt_rd_stb, ovf_clr,
        input  evt_valid, evt_data, evt_overflow
    );

    modport slave (
        input  evt_rd_stb, ovf_clr,
        output evt_valid, evt_data, evt_overflow
    );
endinterface
`default_nettype wire

// File: rtl/front_panel_encoder_hub.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | front_panel_encoder_hub                                               |
// | Multi-channel debounced quadrature decoder with arbitrated event FIFO.|
// | Optional macro ENC_ACCEL_EN: fast detent pairs step the count by 4.   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module front_panel_encoder_hub #(
    parameter int NUM_ENC         = 2,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int CNT_W           = 8,
    parameter int FIFO_DEPTH      = 8,
    parameter int ACCEL_WINDOW    = 50000
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_ENC-1:0]       enc_a,
    input  logic [NUM_ENC-1:0]       enc_b,
    input  logic [NUM_ENC-1:0]       enc_sw,
    input  logic [NUM_ENC-1:0]       pos_clr,
    output logic [NUM_ENC*CNT_W-1:0] position,
    front_panel_encoder_hub_if.slave cpu
);
    localparam int c_nin  = 3 * NUM_ENC;
    localparam int c_db_w = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_aw   = $clog2(FIFO_DEPTH);

    logic [c_nin-1:0]   w_raw, w_deb;
    logic [NUM_ENC-1:0] w_deb_a, w_deb_b, w_deb_sw;

    assign w_raw    = {enc_sw, enc_b, enc_a};
    assign w_deb_a  = w_deb[NUM_ENC-1:0];
    assign w_deb_b  = w_deb[2*NUM_ENC-1:NUM_ENC];
    assign w_deb_sw = w_deb[3*NUM_ENC-1:2*NUM_ENC];

    for (genvar j = 0; j < c_nin; j++) begin : g_db
        logic              r_s1, r_s2, r_deb;
        logic [c_db_w-1:0] r_cnt;
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_s1  <= 1'b0;
                r_s2  <= 1'b0;
                r_deb <= 1'b0;
                r_cnt <= '0;
            end else begin
                r_s1 <= w_raw[j];
                r_s2 <= r_s1;
                if (r_s2 == r_deb) begin
                    r_cnt <= '0;
                end else if (r_cnt == c_db_w'(DEBOUNCE_CYCLES - 1)) begin
                    r_deb <= r_s2;
                    r_cnt <= '0;
                end else begin
                    r_cnt <= r_cnt + c_db_w'(1);
                end
            end
        end
        assign w_deb[j] = r_deb;
    end

    logic [NUM_ENC-1:0] w_pend_rot, w_pend_sw, w_rot_cw, w_rot_sw, w_sw_lvl;
    logic [NUM_ENC-1:0] w_gnt_rot, w_gnt_sw, w_ovr;

    for (genvar i = 0; i < NUM_ENC; i++) begin : g_ch
        logic [1:0]       r_ba_q;
        logic             r_sw_q;
        logic [CNT_W-1:0] r_pos;
        logic             r_pend_rot, r_rot_cw, r_rot_sw, r_pend_sw, r_sw_lvl;
        logic [1:0]       w_ba;
        logic             w_cw, w_ccw, w_rot_evt, w_sw_edge;
        logic [CNT_W-1:0] w_step;

        assign w_ba      = {w_deb_b[i], w_deb_a[i]};
        // Only the return to the 00 detent counts; two-bit jumps never match.
        assign w_cw      = (r_ba_q == 2'b10) && (w_ba == 2'b00);
        assign w_ccw     = (r_ba_q == 2'b01) && (w_ba == 2'b00);
        assign w_rot_evt = w_cw || w_ccw;
        assign w_sw_edge = (w_deb_sw[i] != r_sw_q);

`ifdef ENC_ACCEL_EN
        localparam int c_tmr_w = $clog2(ACCEL_WINDOW + 1);
        localparam logic [c_tmr_w-1:0] c_tmr_sat = c_tmr_w'(ACCEL_WINDOW);
        logic [c_tmr_w-1:0] r_tmr;
        logic               r_last_cw;

        assign w_step = ((r_tmr < c_tmr_sat) && (w_cw == r_last_cw)) ? CNT_W'(4) : CNT_W'(1);

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_tmr     <= c_tmr_sat;
                r_last_cw <= 1'b0;
            end else begin
                if (w_rot_evt)
                    r_last_cw <= w_cw;
                if (pos_clr[i] || (w_rot_evt && (w_cw != r_last_cw)))
                    r_tmr <= c_tmr_sat;
                else if (w_rot_evt)
                    r_tmr <= '0;
                else if (r_tmr != c_tmr_sat)
                    r_tmr <= r_tmr + c_tmr_w'(1);
            end
        end
`else
        assign w_step = CNT_W'(1);
`endif

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_ba_q     <= 2'b00;
                r_sw_q     <= 1'b0;
                r_pos      <= '0;
                r_pend_rot <= 1'b0;
                r_rot_cw   <= 1'b0;
                r_rot_sw   <= 1'b0;
                r_pend_sw  <= 1'b0;
                r_sw_lvl   <= 1'b0;
            end else begin
                r_ba_q <= w_ba;
                r_sw_q <= w_deb_sw[i];
                if (pos_clr[i])
                    r_pos <= '0;
                else if (w_cw)
                    r_pos <= r_pos + w_step;
                else if (w_ccw)
                    r_pos <= r_pos - w_step;

                if (w_rot_evt) begin
                    r_pend_rot <= 1'b1;
                    r_rot_cw   <= w_cw;
                    r_rot_sw   <= w_deb_sw[i];
                end else if (w_gnt_rot[i]) begin
                    r_pend_rot <= 1'b0;
                end

                if (w_sw_edge) begin
                    r_pend_sw <= 1'b1;
                    r_sw_lvl  <= w_deb_sw[i];
                end else if (w_gnt_sw[i]) begin
                    r_pend_sw <= 1'b0;
                end
            end
        end

        assign position[i*CNT_W +: CNT_W] = r_pos;
        assign w_pend_rot[i] = r_pend_rot;
        assign w_pend_sw[i]  = r_pend_sw;
        assign w_rot_cw[i]   = r_rot_cw;
        assign w_rot_sw[i]   = r_rot_sw;
        assign w_sw_lvl[i]   = r_sw_lvl;
        assign w_ovr[i]      = (w_rot_evt && r_pend_rot && !w_gnt_rot[i]) ||
                               (w_sw_edge && r_pend_sw && !w_gnt_sw[i]);
    end

    logic       w_push;
    logic [7:0] w_push_data;

    always_comb begin
        w_push      = 1'b0;
        w_push_data = 8'h00;
        w_gnt_rot   = '0;
        w_gnt_sw    = '0;
        for (int i = 0; i < NUM_ENC; i++) begin
            if (!w_push) begin
                if (w_pend_rot[i]) begin
                    w_push       = 1'b1;
                    w_gnt_rot[i] = 1'b1;
                    w_push_data  = {w_rot_sw[i], w_rot_cw[i], 2'b00, 4'(i)};
                end else if (w_pend_sw[i]) begin
                    w_push      = 1'b1;
                    w_gnt_sw[i] = 1'b1;
                    w_push_data = {w_sw_lvl[i], 1'b0, 1'b1, 1'b0, 4'(i)};
                end
            end
        end
    end

    logic [7:0]    r_mem [FIFO_DEPTH];
    logic [c_aw-1:0] r_wp, r_rp;
    logic [c_aw:0]   r_cnt;
    logic            r_ovf;
    logic            w_full, w_pop, w_wr, w_drop;

    assign w_full = (r_cnt == (c_aw + 1)'(FIFO_DEPTH));
    assign w_pop  = cpu.evt_rd_stb && (r_cnt != '0);
    // A pop frees the slot in the same cycle, so a full FIFO still accepts.
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wp] <= w_push_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (w_wr)
                r_wp <= r_wp + c_aw'(1);
            if (w_pop)
                r_rp <= r_rp + c_aw'(1);
            if (w_wr && !w_pop)
                r_cnt <= r_cnt + (c_aw + 1)'(1);
            else if (!w_wr && w_pop)
                r_cnt <= r_cnt - (c_aw + 1)'(1);
            if (w_drop || (|w_ovr))
                r_ovf <= 1'b1;
            else if (cpu.ovf_clr)
                r_ovf <= 1'b0;
        end
    end

    assign cpu.evt_valid    = (r_cnt != '0);
    assign cpu.evt_data     = (r_cnt != '0) ? r_mem[r_rp] : 8'h00;
    assign cpu.evt_overflow = r_ovf;
endmodule
`default_nettype wire
